// File: rtl/lamp_ctrl_timed.sv
// Multi-switch lamp controller: per-channel debounce, odd-commit toggle of the lamp.
// Optional auto-off timer enabled with `define AUTO_OFF_EN.
module lamp_ctrl_timed #(
   parameter int N_SW    = 3,
   parameter int DEB_CYC = 4,
   parameter int DW      = 8,
   parameter int TIMEOUT = 1000,
   parameter int TW      = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_SW-1:0] S,
   output logic            F,
   output logic [N_SW-1:0] S_db,
   output logic            off_pulse
);

   localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYC - 1);

   logic [N_SW-1:0]         s_db_q, s_db_d;
   logic [N_SW-1:0][DW-1:0] cnt_q, cnt_d;
   logic [N_SW-1:0]         commit;
   logic                    evt;
   logic                    f_q, f_d;

   // A raw level must differ from the committed one for DEB_CYC edges in a row.
   always_comb begin
      s_db_d = s_db_q;
      cnt_d  = '0;
      commit = '0;
      for (int i = 0; i < N_SW; i++) begin
         if (S[i] != s_db_q[i]) begin
            if (cnt_q[i] < DEB_MAX) begin
               cnt_d[i] = cnt_q[i] + DW'(1);
            end else begin
               commit[i] = 1'b1;
               s_db_d[i] = S[i];
            end
         end
      end
      evt = ^commit;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s_db_q <= '0;
         cnt_q  <= '0;
         f_q    <= 1'b0;
      end else begin
         s_db_q <= s_db_d;
         cnt_q  <= cnt_d;
         f_q    <= f_d;
      end
   end

`ifdef AUTO_OFF_EN
   localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT - 1);

   logic [TW-1:0] timer_q, timer_d;
   logic          off_q, off_d;

   // An event always wins over a timeout landing on the same edge.
   always_comb begin
      f_d     = f_q ^ evt;
      timer_d = '0;
      off_d   = 1'b0;
      if (f_q && !evt) begin
         if (timer_q == T_MAX) begin
            f_d   = 1'b0;
            off_d = 1'b1;
         end else begin
            timer_d = timer_q + TW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         timer_q <= '0;
         off_q   <= 1'b0;
      end else begin
         timer_q <= timer_d;
         off_q   <= off_d;
      end
   end

   assign off_pulse = off_q;
`else
   logic [TW-1:0] unused_timeout;

   assign unused_timeout = TW'(TIMEOUT);

   always_comb begin
      f_d = f_q ^ evt;
   end

   assign off_pulse = 1'b0;
`endif

   assign F    = f_q;
   assign S_db = s_db_q;

endmodule

// File: tb/tb_lamp_ctrl_timed.sv
// Self-checking bench for lamp_ctrl_timed: vector table plus hand-written timer/reset corners.
// Expectations for the auto-off sequence follow whether AUTO_OFF_EN is defined.
module tb_lamp_ctrl_timed;

   logic       clk;
   logic       rst_n;
   logic [2:0] S;
   logic       F;
   logic [2:0] S_db;
   logic       off_pulse;

   int compared = 0;
   int mismatched = 0;

   typedef struct {
      logic       rst_n;
      logic [2:0] s;
      logic       exp_f;
      logic [2:0] exp_sdb;
      logic       exp_off;
      string      name;
   } vec_t;

   typedef struct {
      logic       f;
      logic [2:0] sdb;
      logic       off;
      string      name;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   lamp_ctrl_timed #(
      .N_SW(3), .DEB_CYC(4), .DW(8), .TIMEOUT(20), .TW(16)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .S(S),
      .F(F),
      .S_db(S_db),
      .off_pulse(off_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pops the oldest expectation and compares it against the settled outputs.
   task automatic checkOutput();
      exp_t e;
      if (sb.size() == 0) return;
      e = sb.pop_front();
      compared++;
      if ({F, S_db, off_pulse} !== {e.f, e.sdb, e.off}) begin
         mismatched++;
         $display("[TB] FAIL %s: got F=%b S_db=%b off_pulse=%b, want F=%b S_db=%b off_pulse=%b",
                  e.name, F, S_db, off_pulse, e.f, e.sdb, e.off);
      end
   endtask

   // Drives one edge worth of stimulus, queues the expectation, checks after the edge.
   task automatic applyStimulus(input logic r, input logic [2:0] s, input logic ef,
                                input logic [2:0] esdb, input logic eoff, input string nm);
      exp_t e;
      @(negedge clk);
      rst_n = r;
      S     = s;
      e.f = ef; e.sdb = esdb; e.off = eoff; e.name = nm;
      sb.push_back(e);
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   task automatic holdSteps(input logic r, input logic [2:0] s, input int n, input logic ef,
                            input logic [2:0] esdb, input logic eoff, input string nm);
      for (int k = 0; k < n; k++) applyStimulus(r, s, ef, esdb, eoff, nm);
   endtask

   task automatic addVec(input logic r, input logic [2:0] s, input logic ef,
                         input logic [2:0] esdb, input logic eoff, input string nm);
      vec_t v;
      v.rst_n = r; v.s = s; v.exp_f = ef; v.exp_sdb = esdb; v.exp_off = eoff; v.name = nm;
      vecs.push_back(v);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [2:0] walk [8];
      logic       walk_f [8];
      logic       ef;

      rst_n = 1'b0;
      S     = 3'b000;

      // Reset with switches high, then commit all three after release.
      addVec(0, 3'b111, 0, 3'b000, 0, "reset_hold");
      addVec(0, 3'b111, 0, 3'b000, 0, "reset_hold");
      addVec(1, 3'b111, 0, 3'b000, 0, "release_e1");
      addVec(1, 3'b111, 0, 3'b000, 0, "release_e2");
      addVec(1, 3'b111, 0, 3'b000, 0, "release_e3");
      addVec(1, 3'b111, 1, 3'b111, 0, "release_commit");
      addVec(1, 3'b000, 1, 3'b111, 0, "all_low_e1");
      addVec(1, 3'b000, 1, 3'b111, 0, "all_low_e2");
      addVec(1, 3'b000, 1, 3'b111, 0, "all_low_e3");
      addVec(1, 3'b000, 0, 3'b000, 0, "all_low_commit");
      // Three-edge glitch on S[0] is dropped.
      addVec(1, 3'b001, 0, 3'b000, 0, "glitch_e1");
      addVec(1, 3'b001, 0, 3'b000, 0, "glitch_e2");
      addVec(1, 3'b001, 0, 3'b000, 0, "glitch_e3");
      addVec(1, 3'b000, 0, 3'b000, 0, "glitch_gone");
      addVec(1, 3'b000, 0, 3'b000, 0, "glitch_gone");
      addVec(1, 3'b001, 0, 3'b000, 0, "s0_e1");
      addVec(1, 3'b001, 0, 3'b000, 0, "s0_e2");
      addVec(1, 3'b001, 0, 3'b000, 0, "s0_e3");
      addVec(1, 3'b001, 1, 3'b001, 0, "s0_commit");
      // Two channels committing together leave the lamp alone.
      addVec(1, 3'b010, 1, 3'b001, 0, "dual_e1");
      addVec(1, 3'b010, 1, 3'b001, 0, "dual_e2");
      addVec(1, 3'b010, 1, 3'b001, 0, "dual_e3");
      addVec(1, 3'b010, 1, 3'b010, 0, "dual_commit");

      for (int i = 0; i < vecs.size(); i++)
         applyStimulus(vecs[i].rst_n, vecs[i].s, vecs[i].exp_f, vecs[i].exp_sdb,
                       vecs[i].exp_off, vecs[i].name);

      // Staircase walk; commits are 8 edges apart so the timer never expires.
      walk[0] = 3'b000; walk[1] = 3'b001; walk[2] = 3'b011; walk[3] = 3'b010;
      walk[4] = 3'b110; walk[5] = 3'b111; walk[6] = 3'b101; walk[7] = 3'b100;
      walk_f[0] = 0; walk_f[1] = 1; walk_f[2] = 0; walk_f[3] = 1;
      walk_f[4] = 0; walk_f[5] = 1; walk_f[6] = 0; walk_f[7] = 1;
      holdSteps(0, 3'b000, 2, 0, 3'b000, 0, "walk_reset");
      for (int i = 0; i < 8; i++) begin
         for (int k = 0; k < 3; k++) @(negedge clk) S = walk[i];
         applyStimulus(1, walk[i], walk_f[i], walk[i], 0, "walk_commit");
         for (int k = 0; k < 3; k++) @(negedge clk);
         applyStimulus(1, walk[i], walk_f[i], walk[i], 0, "walk_hold");
      end

      // Auto-off: F rises at edge t, no further stimulus.
      holdSteps(0, 3'b000, 2, 0, 3'b000, 0, "ao_reset");
      holdSteps(1, 3'b001, 3, 0, 3'b000, 0, "ao_rise_wait");
      applyStimulus(1, 3'b001, 1, 3'b001, 0, "ao_rise");
      holdSteps(1, 3'b001, 19, 1, 3'b001, 0, "ao_on");
`ifdef AUTO_OFF_EN
      applyStimulus(1, 3'b001, 0, 3'b001, 1, "ao_fire");
      applyStimulus(1, 3'b001, 0, 3'b001, 0, "ao_pulse_clear");
      ef = 1'b0;
`else
      applyStimulus(1, 3'b001, 1, 3'b001, 0, "ao_no_timer");
      applyStimulus(1, 3'b001, 1, 3'b001, 0, "ao_no_timer");
      ef = 1'b1;
`endif
      holdSteps(1, 3'b011, 3, ef, 3'b001, 0, "ao_toggle_wait");
      applyStimulus(1, 3'b011, ~ef, 3'b011, 0, "ao_toggle");

      // Event lands on the same edge as the timeout: the event wins.
      holdSteps(0, 3'b000, 2, 0, 3'b000, 0, "race_reset");
      holdSteps(1, 3'b001, 3, 0, 3'b000, 0, "race_rise_wait");
      applyStimulus(1, 3'b001, 1, 3'b001, 0, "race_rise");
      holdSteps(1, 3'b001, 16, 1, 3'b001, 0, "race_on");
      holdSteps(1, 3'b011, 3, 1, 3'b001, 0, "race_deb");
      applyStimulus(1, 3'b011, 0, 3'b011, 0, "race_edge");
      applyStimulus(1, 3'b011, 0, 3'b011, 0, "race_after");

      // Reset with cnt[0]=2 discards the pending commit.
      holdSteps(0, 3'b000, 2, 0, 3'b000, 0, "mid_reset_init");
      holdSteps(1, 3'b001, 2, 0, 3'b000, 0, "mid_cnt");
      applyStimulus(0, 3'b001, 0, 3'b000, 0, "mid_reset");
      holdSteps(1, 3'b001, 3, 0, 3'b000, 0, "mid_no_commit");
      applyStimulus(1, 3'b001, 1, 3'b001, 0, "mid_fresh_commit");

      if (sb.size() != 0) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
